// File: rtl/store_pkg.sv
// Shared types and constants for the posted-store buffer.
package store_pkg;

   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;

   // Entry address field width; must match the controller's ADDR_W.
   localparam int ST_ADDR_W = 32;

   typedef struct packed {
      logic [ST_ADDR_W-1:0] addr;
      logic [31:0]          wdata;
      logic [3:0]           wstrb;
   } st_entry_t;

   typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;

endpackage

// File: rtl/store_lane_align.sv
// Combinational SB/SH/SW formatter: replicates store data across lanes and
// derives byte strobes and the misalignment flag from addr[1:0].
module store_lane_align
   import store_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   input  logic [31:0] data,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        misalign
);

   always_comb begin
      wdata    = '0;
      wstrb    = '0;
      misalign = 1'b0;
      case (funct3)
         F3_SB: begin
            wdata = {4{data[7:0]}};
            wstrb = 4'b0001 << addr_lo;
         end
         F3_SH: begin
            wdata    = {2{data[15:0]}};
            wstrb    = addr_lo[1] ? 4'b1100 : 4'b0011;
            misalign = addr_lo[0];
         end
         F3_SW: begin
            wdata    = data;
            wstrb    = 4'b1111;
            misalign = (addr_lo != 2'b00);
         end
         default: misalign = 1'b1;
      endcase
   end

endmodule

// File: rtl/store_buffer_ctrl.sv
// Posted-store buffer: DEPTH-entry FIFO draining to a valid/ready write port,
// with fence sequencing. Define STBUF_FWD_EN to build the load-hazard compare.
module store_buffer_ctrl
   import store_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic [31:0]       st_data,
   input  logic [2:0]        st_funct3,
   output logic              st_misalign,
   input  logic              fence_req,
   output logic              fence_done,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   output logic              empty,
   input  logic [ADDR_W-1:0] ld_chk_addr,
   output logic              ld_hazard
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [31:0]      fmt_wdata;
   logic [3:0]       fmt_wstrb;
   logic             fmt_mis;
   st_entry_t        fifo_q [DEPTH];
   st_entry_t        head;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   state_e           state_q;
   logic             misalign_q, fence_done_q;
   logic             accept, enq, deq;

   store_lane_align u_align (
      .addr_lo  (st_addr[1:0]),
      .funct3   (st_funct3),
      .data     (st_data),
      .wdata    (fmt_wdata),
      .wstrb    (fmt_wstrb),
      .misalign (fmt_mis)
   );

   // Rejected stores still complete the handshake but never enter the queue.
   assign st_ready = !rst && (state_q == RUN) && (count_q < DEPTH_C);
   assign accept   = st_valid && st_ready;
   assign enq      = accept && !fmt_mis;
   assign deq      = mem_valid && mem_ready;

   assign empty       = (count_q == '0);
   assign head        = fifo_q[rd_ptr_q];
   assign mem_valid   = !empty;
   assign mem_addr    = empty ? '0 : ADDR_W'(head.addr);
   assign mem_wdata   = empty ? '0 : head.wdata;
   assign mem_wstrb   = empty ? '0 : head.wstrb;
   assign st_misalign = misalign_q;
   assign fence_done  = fence_done_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({enq, deq})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         fifo_q[wr_ptr_q].addr  <= ST_ADDR_W'({st_addr[ADDR_W-1:2], 2'b00});
         fifo_q[wr_ptr_q].wdata <= fmt_wdata;
         fifo_q[wr_ptr_q].wstrb <= fmt_wstrb;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         state_q      <= RUN;
         misalign_q   <= 1'b0;
         fence_done_q <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         misalign_q   <= accept && fmt_mis;
         fence_done_q <= 1'b0;
         case (state_q)
            RUN:   if (fence_req) state_q <= DRAIN;
            DRAIN: if (empty) begin
                      state_q      <= DONE;
                      fence_done_q <= 1'b1;
                   end
            DONE:  state_q <= RUN;
            default: state_q <= RUN;
         endcase
      end
   end

`ifdef STBUF_FWD_EN
   logic [ST_ADDR_W-1:0] ld_word;
   logic                 unused_ld_lo;

   assign ld_word      = ST_ADDR_W'({ld_chk_addr[ADDR_W-1:2], 2'b00});
   assign unused_ld_lo = ^ld_chk_addr[1:0];

   // An entry is live when its distance from the head is below the count;
   // the head stays visible during the cycle it is being acknowledged.
   always_comb begin
      ld_hazard = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (({1'b0, PTR_W'(i) - rd_ptr_q} < count_q) && (fifo_q[i].addr == ld_word))
            ld_hazard = 1'b1;
      end
   end
`else
   logic unused_ld;

   assign unused_ld = ^ld_chk_addr;
   assign ld_hazard = 1'b0;
`endif

endmodule

// File: tb/tb_store_buffer_ctrl.sv
// Scoreboard bench for store_buffer_ctrl; hazard expectations follow STBUF_FWD_EN.
module tb_store_buffer_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [2:0]  st_funct3;
   logic        st_misalign;
   logic        fence_req;
   logic        fence_done;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        empty;
   logic [31:0] ld_chk_addr;
   logic        ld_hazard;

   int errors = 0;
   int checks = 0;

`ifdef STBUF_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   store_buffer_ctrl #(.DEPTH(4), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
      .st_data(st_data), .st_funct3(st_funct3), .st_misalign(st_misalign),
      .fence_req(fence_req), .fence_done(fence_done),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .empty(empty),
      .ld_chk_addr(ld_chk_addr), .ld_hazard(ld_hazard)
   );

   function automatic void model_fmt(input logic [31:0] a, input logic [31:0] d,
                                     input logic [2:0] f3, output exp_t e, output bit bad);
      e.addr  = {a[31:2], 2'b00};
      e.wdata = 32'h0;
      e.wstrb = 4'h0;
      bad     = 1'b0;
      case (f3)
         3'b000: begin e.wdata = {4{d[7:0]}}; e.wstrb = 4'b0001 << a[1:0]; end
         3'b001: begin e.wdata = {2{d[15:0]}}; e.wstrb = a[1] ? 4'b1100 : 4'b0011; bad = a[0]; end
         3'b010: begin e.wdata = d; e.wstrb = 4'b1111; bad = (a[1:0] != 2'b00); end
         default: bad = 1'b1;
      endcase
   endfunction

   // Scoreboard consumer: every memory handshake must match the oldest expected store.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && mem_valid && mem_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL drain_unexpected: addr=%h wdata=%h, required no transfer", mem_addr, mem_wdata);
         end else begin
            e = exp_q.pop_front();
            if ({mem_addr, mem_wdata, mem_wstrb} !== e) begin
               errors++;
               $display("FAIL drain_order: got %h/%h/%b required %h/%h/%b",
                        mem_addr, mem_wdata, mem_wstrb, e.addr, e.wdata, e.wstrb);
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accept edge.
   task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
      exp_t e;
      bit   bad;
      int   n;
      model_fmt(a, d, f3, e, bad);
      st_valid = 1'b1; st_addr = a; st_data = d; st_funct3 = f3;
      n = 0;
      @(negedge clk);
      while (!st_ready && n < 50) begin
         @(posedge clk); #1;
         @(negedge clk);
         n++;
      end
      if (!st_ready) begin
         checks++; errors++;
         $display("FAIL push_timeout: st_ready=%b required 1", st_ready);
      end else if (!bad) begin
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      st_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; st_funct3 = '0;
      fence_req = 1'b0; mem_ready = 1'b0; ld_chk_addr = '0;
      @(negedge clk);
      checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL rst_st_ready: got %b required 0", st_ready); end
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid: got %b required 0", mem_valid); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b required 1", empty); end
      checks++; if ({st_misalign, fence_done, ld_hazard} !== 3'b000) begin errors++; $display("FAIL rst_pulses: got %b required 000", {st_misalign, fence_done, ld_hazard}); end
      checks++; if ({mem_addr, mem_wdata, mem_wstrb} !== 68'h0) begin errors++; $display("FAIL rst_mem_bus: got %h/%h/%b required 0", mem_addr, mem_wdata, mem_wstrb); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %b required 1", st_ready); end
      @(posedge clk); #1;
   endtask

   task automatic test_sb;
      mem_ready = 1'b1;
      push_store(32'h0000_1003, 32'hAABB_CCDD, 3'b000);
      @(negedge clk);
      checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL sb_valid: got %b required 1", mem_valid); end
      checks++; if (mem_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr: got %h required 00001000", mem_addr); end
      checks++; if (mem_wdata !== 32'hDDDD_DDDD) begin errors++; $display("FAIL sb_wdata: got %h required dddddddd", mem_wdata); end
      checks++; if (mem_wstrb !== 4'b1000) begin errors++; $display("FAIL sb_wstrb: got %b required 1000", mem_wstrb); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sb_empty: got %b required 1", empty); end
      @(posedge clk); #1;
   endtask

   task automatic test_sh_misalign;
      mem_ready = 1'b1;
      push_store(32'h0000_2002, 32'h0000_1234, 3'b001);
      @(negedge clk);
      checks++; if (mem_addr !== 32'h0000_2000) begin errors++; $display("FAIL sh_addr: got %h required 00002000", mem_addr); end
      checks++; if (mem_wdata !== 32'h1234_1234) begin errors++; $display("FAIL sh_wdata: got %h required 12341234", mem_wdata); end
      checks++; if (mem_wstrb !== 4'b1100) begin errors++; $display("FAIL sh_wstrb: got %b required 1100", mem_wstrb); end
      @(posedge clk); #1;
      push_store(32'h0000_2001, 32'hCAFE_F00D, 3'b010);
      @(negedge clk);
      checks++; if (st_misalign !== 1'b1) begin errors++; $display("FAIL sw_misalign_pulse: got %b required 1", st_misalign); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sw_misalign_empty: got %b required 1", empty); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (st_misalign !== 1'b0) begin errors++; $display("FAIL misalign_one_cycle: got %b required 0", st_misalign); end
      @(posedge clk); #1;
      push_store(32'h0000_2000, 32'h0000_0001, 3'b011);
      @(negedge clk);
      checks++; if ({st_misalign, empty} !== 2'b11) begin errors++; $display("FAIL bad_funct3: got misalign/empty=%b required 11", {st_misalign, empty}); end
      @(posedge clk); #1;
   endtask

   task automatic test_full_wrap;
      exp_t e;
      bit   bad;
      bit   exp_rdy;
      mem_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         st_valid = 1'b1; st_addr = 32'h4000 + 32'(4 * k);
         st_data = 32'h1111_0000 + 32'(k); st_funct3 = 3'b010;
         exp_rdy = (k < 4);
         @(negedge clk);
         checks++; if (st_ready !== exp_rdy) begin errors++; $display("FAIL full_ready[%0d]: got %b required %b", k, st_ready, exp_rdy); end
         if (st_ready) begin
            model_fmt(st_addr, st_data, st_funct3, e, bad);
            exp_q.push_back(e);
         end
         @(posedge clk); #1;
      end
      st_valid = 1'b0;
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h4000 + 32'(4 * i)) begin
            errors++; $display("FAIL fifo_order[%0d]: got valid=%b addr=%h required 1/%h", i, mem_valid, mem_addr, 32'h4000 + 32'(4 * i));
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drained: got %b required 1", empty); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      logic [2:0]  f3;
      logic [31:0] a;
      int          n;
      mem_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         f3 = 3'(i % 3);
         a  = 32'h5000 + 32'(4 * i);
         if (f3 == 3'b000) a = a + 32'(i % 4);
         if (f3 == 3'b001) a = a + 32'(2 * (i % 2));
         push_store(a, $urandom, f3);
      end
      n = 0;
      while (!empty && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      checks++; if (empty !== 1'b1 || exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: empty=%b pending=%0d required 1/0", empty, exp_q.size()); end
   endtask

   task automatic test_fence;
      bit done_seen = 1'b0;
      bit finished  = 1'b0;
      mem_ready = 1'b0;
      push_store(32'h6000, 32'hA0A0_0001, 3'b010);
      push_store(32'h6004, 32'hA0A0_0002, 3'b010);
      push_store(32'h6008, 32'hA0A0_0003, 3'b010);
      fence_req = 1'b1;
      @(posedge clk); #1;
      fence_req = 1'b0;
      for (int c = 0; c < 40 && !finished; c++) begin
         mem_ready = (c % 2 == 0);
         @(negedge clk);
         if (done_seen) begin
            checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL fence_resume_ready: got %b required 1", st_ready); end
            checks++; if (fence_done !== 1'b0) begin errors++; $display("FAIL fence_done_width: got %b required 0", fence_done); end
            finished = 1'b1;
         end else if (fence_done) begin
            done_seen = 1'b1;
            checks++; if ({empty, st_ready} !== 2'b10) begin errors++; $display("FAIL fence_done_state: empty/ready=%b required 10", {empty, st_ready}); end
         end else begin
            checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL fence_drain_ready[%0d]: got %b required 0", c, st_ready); end
         end
         @(posedge clk); #1;
      end
      if (!finished) begin checks++; errors++; $display("FAIL fence_timeout: fence_done seen=%b required 1", done_seen); end
      mem_ready = 1'b0;
   endtask

   task automatic test_hazard;
      mem_ready = 1'b0;
      push_store(32'h3001, 32'h0000_005A, 3'b000);
      ld_chk_addr = 32'h3003;
      @(negedge clk);
      checks++; if (ld_hazard !== FWD) begin errors++; $display("FAIL hazard_same_word: got %b required %b", ld_hazard, FWD); end
      @(posedge clk); #1;
      ld_chk_addr = 32'h3004;
      @(negedge clk);
      checks++; if (ld_hazard !== 1'b0) begin errors++; $display("FAIL hazard_next_word: got %b required 0", ld_hazard); end
      @(posedge clk); #1;
      ld_chk_addr = 32'h3000;
      mem_ready = 1'b1;
      @(negedge clk);
      checks++; if (ld_hazard !== FWD) begin errors++; $display("FAIL hazard_head_acked: got %b required %b", ld_hazard, FWD); end
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if ({empty, ld_hazard} !== 2'b10) begin errors++; $display("FAIL hazard_after_drain: empty/hazard=%b required 10", {empty, ld_hazard}); end
      @(posedge clk); #1;
      ld_chk_addr = '0;
      mem_ready = 1'b0;
   endtask

   task automatic test_reset_mid;
      mem_ready = 1'b0;
      push_store(32'h7000, 32'hDEAD_0001, 3'b010);
      push_store(32'h7004, 32'hDEAD_0002, 3'b010);
      @(negedge clk);
      checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL mid_pending: got %b required 1", mem_valid); end
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b required 0", st_ready); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checks++; if ({mem_valid, empty} !== 2'b01) begin errors++; $display("FAIL mid_flushed: valid/empty=%b required 01", {mem_valid, empty}); end
      @(posedge clk); #1;
      mem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL mid_stale[%0d]: got %b required 0", i, mem_valid); end
         @(posedge clk); #1;
      end
      push_store(32'h7100, 32'hBEEF_0003, 3'b010);
      @(negedge clk);
      checks++; if (mem_addr !== 32'h7100) begin errors++; $display("FAIL mid_fresh_addr: got %h required 00007100", mem_addr); end
      @(posedge clk); #1;
      mem_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_sb();
      test_sh_misalign();
      test_full_wrap();
      test_back_to_back();
      test_fence();
      test_hazard();
      test_reset_mid();
      @(negedge clk);
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover: pending=%0d required 0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/store_buffer_ctrl.md
Name: store_buffer_ctrl

Overview:
- Posted-store controller between the core's store path and the data-memory write port.
- Accepts RISC-V SB/SH/SW requests and lane-aligns data into a replicated word with byte strobes.
- Queues stores in a DEPTH-entry FIFO and drains them to memory with a valid/ready handshake.
- Provides a fence/drain sequence and misalignment reporting.

Parameters:
- DEPTH, 4, number of queued store entries; power of two, at least 2.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  core presents a store
- st_ready  out  1  controller can accept a store this cycle
- st_addr  in  ADDR_W  byte address
- st_data  in  32  rs2 value, unformatted
- st_funct3  in  3  000=SB, 001=SH, 010=SW
- st_misalign  out  1  one-cycle pulse: last accepted store was rejected
- fence_req  in  1  level; request drain of all queued stores
- fence_done  out  1  one-cycle pulse when drain completes
- mem_valid  out  1  memory write request
- mem_ready  in  1  memory accepts the write
- mem_addr  out  ADDR_W  word-aligned address, bits [1:0] always 0
- mem_wdata  out  32  lane-replicated data
- mem_wstrb  out  4  byte-lane enables
- empty  out  1  no entries queued
- ld_chk_addr  in  ADDR_W  load address for hazard check
- ld_hazard  out  1  queued store overlaps the load's word

Behaviour:
- Reset values:
  - st_ready=0 during the reset cycle, 1 afterwards.
  - mem_valid=0, st_misalign=0, fence_done=0, empty=1, ld_hazard=0.
  - mem_addr, mem_wdata and mem_wstrb are 0.
  - Pointers and count are 0; FSM is in RUN.
- Store formatting:
  - SB: wdata = {4{data[7:0]}}, wstrb = 4'b0001 << addr[1:0].
  - SH: wdata = {2{data[15:0]}}, wstrb = addr[1] ? 4'b1100 : 4'b0011.
  - SW: wdata = data, wstrb = 4'b1111.
  - Entry address is {addr[ADDR_W-1:2], 2'b00}.
- Acceptance:
  - A store is accepted on st_valid && st_ready.
  - st_ready = (state==RUN) && (count<DEPTH). There is no same-cycle pass-through when full, even if a dequeue occurs.
- Rejection:
  - Rejected cases: SH with addr[0]=1, SW with addr[1:0]!=0, or funct3 not in {000,001,010}.
  - A rejected store is still handshaked: st_ready behaves as for a valid store.
  - It is not enqueued, and st_misalign pulses the following cycle.
- Latency: a store accepted at edge N drives mem_valid=1 from cycle N+1, when the queue was empty.
- Memory handshake:
  - mem_valid = !empty.
  - mem_addr, mem_wdata and mem_wstrb come from the head entry and hold stable until mem_valid && mem_ready.
  - Dequeue happens on that edge.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance (wrap modulo DEPTH).
- FSM:
  - RUN -> DRAIN when fence_req=1. If already empty, it still passes through DRAIN for one cycle.
  - DRAIN: st_ready=0, dequeues continue; -> DONE when empty=1.
  - DONE: fence_done=1 for exactly one cycle; -> RUN.
  - fence_req is ignored outside RUN.
  - The core must hold fence_req low after fence_done, else a new drain starts.
- Reset mid-operation: all queued entries are discarded, including a pending unacknowledged mem transfer. mem_valid drops at the reset edge. The memory side must tolerate abandoned requests.

Optional Feature:
- Macro: STBUF_FWD_EN.
- Defined: ld_hazard=1 combinationally when any valid entry's word address equals {ld_chk_addr[ADDR_W-1:2],2'b00}. The head entry is included even while it is being acknowledged. The core stalls the load on ld_hazard.
- Undefined: ld_hazard is tied to 0, no comparators are built, and the port list is unchanged.

Decomposition:
- Package store_pkg:
  - Constants F3_SB=3'b000, F3_SH=3'b001, F3_SW=3'b010.
  - Typedef st_entry_t {addr, wdata, wstrb}.
  - FSM enum {RUN, DRAIN, DONE}.
- Sub-module store_lane_align: combinational formatter (addr[1:0], funct3, data -> wdata, wstrb, misalign).
- The controller owns the FIFO, the FSM and the hazard compare.

Test Plan:
- SB addr=0x1003, data=0xAABBCCDD, mem_ready=1 -> next cycle mem_addr=0x1000, mem_wdata=0xDDDDDDDD, mem_wstrb=4'b1000; dequeue; empty=1.
- SH addr=0x2002, data=0x00001234 -> mem_wdata=0x12341234, wstrb=4'b1100. Separately, SW addr=0x2001 -> accepted, not enqueued, st_misalign pulses, empty stays 1.
- mem_ready=0, issue 5 SW back to back -> 4 accepted, st_ready=0 on the 5th. Raise mem_ready -> drained in FIFO order, one per cycle; pointer wrap verified.
- 3 stores queued, mem_ready toggling 1/0, fence_req=1 -> st_ready=0 until empty, then fence_done pulses once, then st_ready=1.
- 2 entries queued, mem_valid high with mem_ready=0, assert rst one cycle -> next cycle mem_valid=0, empty=1, no stale entry issued afterward.
- With STBUF_FWD_EN: queue SB 0x3001 (mem_ready=0), ld_chk_addr=0x3003 -> ld_hazard=1; ld_chk_addr=0x3004 -> ld_hazard=0. Without the macro: ld_hazard=0 in both cases.
